wash_timer_ctrl: RTL and testbench
==================================

WASH_TIMER_CTRL -- requirements
Module: wash_timer_ctrl

Interface
REQ-001 Parameter PRESCALE, default 1000: clock cycles per timer tick, >= 1.
REQ-002 Parameter T_MED, default 30: wash duration in ticks for TIMER_SEL=01, >= 1.
REQ-003 Parameter T_HIGH, default 45: wash duration in ticks for TIMER_SEL=10, >= 1.
REQ-004 Parameter T_SPIN, default 20: spin duration in ticks for TIMER_SEL=11, >= 1.
REQ-005 Parameter CNT_W, default 16: REMAINING width; every duration < 2^CNT_W.
REQ-006 CLK  in  1  single clock; all state changes on the rising edge.
REQ-007 RST  in  1  synchronous, active-low reset.
REQ-008 TIMER_EN  in  1  start/hold request from the washing-machine FSM; low aborts.
REQ-009 TIMER_SEL  in  2  duration select: 01 med, 10 high, 11 spin, 00 invalid.
REQ-010 DOOR_SENSOR  in  1  high = door closed; used only under the pause feature.
REQ-011 TIMER_DONE  out  1  high while in EXPIRED.
REQ-012 BUSY  out  1  high in RUN or PAUSE.
REQ-013 REMAINING  out  CNT_W  ticks left in the current run.
REQ-014 SEL_ERR  out  1  one-cycle pulse when a start is rejected.

Function
REQ-015 States IDLE, RUN, PAUSE, EXPIRED; all outputs registered or decoded from state only.
REQ-016 IDLE, TIMER_EN=1, TIMER_SEL valid: load REMAINING=duration(TIMER_SEL), prescaler=0, go RUN.
REQ-017 IDLE, TIMER_EN=1, TIMER_SEL=00: SEL_ERR=1 next cycle, stay IDLE, REMAINING unchanged.
REQ-018 TIMER_SEL latched at load; changes during RUN/PAUSE/EXPIRED ignored.
REQ-019 RUN: prescaler increments each cycle 0..PRESCALE-1, wraps to 0; on wrap REMAINING decrements by 1.
REQ-020 RUN, wrap with REMAINING=1: REMAINING becomes 0, go EXPIRED same edge.
REQ-021 Latency: TIMER_DONE first high exactly D*PRESCALE edges after the IDLE edge sampling the start (no pause).
REQ-022 RUN or PAUSE, TIMER_EN=0: go IDLE, REMAINING=0, prescaler=0, no TIMER_DONE; abort outranks expiry and pause on the same edge.
REQ-023 EXPIRED: TIMER_DONE held high while TIMER_EN=1; TIMER_EN=0 -> IDLE, REMAINING stays 0.
REQ-024 EXPIRED -> IDLE needs TIMER_EN low for at least one cycle; TIMER_EN held high never restarts.
REQ-025 REMAINING never wraps below 0; prescaler never exceeds PRESCALE-1.

Reset
REQ-026 RST=0 at an edge: state IDLE, REMAINING=0, prescaler=0, TIMER_DONE=0, BUSY=0, SEL_ERR=0.
REQ-027 Reset outranks every other condition, including mid-run and mid-pause.
REQ-028 First cycle after reset release evaluates IDLE rules normally.

Configuration
REQ-029 Macro WASH_TIMER_PAUSE_EN defined: RUN with DOOR_SENSOR=0 -> PAUSE; prescaler and REMAINING frozen.
REQ-030 With WASH_TIMER_PAUSE_EN: PAUSE with DOOR_SENSOR=1 and TIMER_EN=1 -> RUN, resuming from the frozen prescaler value.
REQ-031 With WASH_TIMER_PAUSE_EN: door open on the expiry edge -> pause wins, expiry deferred.
REQ-032 Macro undefined: PAUSE unreachable, DOOR_SENSOR ignored, no pause logic synthesized.

Verification (PRESCALE=4, T_MED=3, T_HIGH=5, T_SPIN=2)
REQ-033 Start SEL=01, EN held -> BUSY next cycle, REMAINING 3->2->1->0 every 4 cycles, TIMER_DONE high 12 edges after start.
REQ-034 Start SEL=00 -> SEL_ERR one-cycle pulse, BUSY=0, state IDLE.
REQ-035 Start SEL=10, drop EN after 7 cycles -> IDLE, REMAINING=0, TIMER_DONE never asserts.
REQ-036 PAUSE_EN: start SEL=11, DOOR_SENSOR=0 for 6 cycles mid-run -> REMAINING frozen, TIMER_DONE at 8+6=14 edges.
REQ-037 RST=0 during RUN with REMAINING=2 -> all outputs 0 next cycle; SEL=01 restart counts full 12 cycles.
REQ-038 EXPIRED, EN held 5 cycles, then low 1 cycle, then high SEL=11 -> TIMER_DONE 5 cycles, IDLE, new 8-cycle run.

Source files
------------

// File: rtl/wash_timer_if.sv
// wash_timer_if
//   Bundles the washing-machine FSM <-> wash timer signals.
//   master : the washing-machine FSM (drives requests, reads status)
//   slave  : wash_timer_ctrl (reads requests, drives status)
//   Signals:
//     TIMER_EN    start/hold request, low aborts
//     TIMER_SEL   duration select: 01 med, 10 high, 11 spin, 00 invalid
//     DOOR_SENSOR high = door closed (only used by the pause feature)
//     TIMER_DONE  high while the timer is expired
//     BUSY        high while a run is in progress (running or paused)
//     REMAINING   ticks left in the current run
//     SEL_ERR     one-cycle pulse when a start is rejected
interface wash_timer_if #(
  parameter int CNT_W = 16
);
  logic             TIMER_EN;
  logic [1:0]       TIMER_SEL;
  logic             DOOR_SENSOR;
  logic             TIMER_DONE;
  logic             BUSY;
  logic [CNT_W-1:0] REMAINING;
  logic             SEL_ERR;

  modport master (
    output TIMER_EN, TIMER_SEL, DOOR_SENSOR,
    input  TIMER_DONE, BUSY, REMAINING, SEL_ERR
  );

  modport slave (
    input  TIMER_EN, TIMER_SEL, DOOR_SENSOR,
    output TIMER_DONE, BUSY, REMAINING, SEL_ERR
  );
endinterface

// File: rtl/wash_timer_ctrl.sv
// wash_timer_ctrl
//   Wash/spin duration timer for a washing-machine controller.  A start
//   request loads the selected duration (in ticks) and counts it down, one
//   tick every PRESCALE clock cycles; TIMER_DONE is held while expired until
//   the request is dropped.
//
//   Optional feature: define WASH_TIMER_PAUSE_EN to freeze the countdown
//   while the door is open (DOOR_SENSOR low).  Without the macro the door
//   input is ignored and no pause state exists in hardware.
//
//   Ports:
//     CLK  single clock, rising edge
//     RST  synchronous, active-low reset
//     bus  wash_timer_if.slave (TIMER_EN, TIMER_SEL, DOOR_SENSOR in;
//          TIMER_DONE, BUSY, REMAINING, SEL_ERR out)
module wash_timer_ctrl #(
  parameter int PRESCALE = 1000,
  parameter int T_MED    = 30,
  parameter int T_HIGH   = 45,
  parameter int T_SPIN   = 20,
  parameter int CNT_W    = 16
) (
  input  logic          CLK,
  input  logic          RST,
  wash_timer_if.slave   bus
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]    P_MAX  = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    P_ZERO = '0;
  localparam logic [PW-1:0]    P_ONE  = PW'(1);
  localparam logic [CNT_W-1:0] C_ZERO = '0;
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] D_MED  = CNT_W'(T_MED);
  localparam logic [CNT_W-1:0] D_HIGH = CNT_W'(T_HIGH);
  localparam logic [CNT_W-1:0] D_SPIN = CNT_W'(T_SPIN);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_PAUSE   = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PW-1:0]    r_presc, w_presc_nxt;
  logic [CNT_W-1:0] r_rem,   w_rem_nxt;
  logic             r_sel_err, w_sel_err_nxt;

  // Duration lookup; 00 never reaches here because it is rejected first.
  function automatic logic [CNT_W-1:0] duration(input logic [1:0] sel);
    case (sel)
      2'b01:   duration = D_MED;
      2'b10:   duration = D_HIGH;
      default: duration = D_SPIN;
    endcase
  endfunction

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state   <= S_IDLE;
      r_presc   <= P_ZERO;
      r_rem     <= C_ZERO;
      r_sel_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_rem     <= w_rem_nxt;
      r_sel_err <= w_sel_err_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_rem_nxt     = r_rem;
    w_sel_err_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.TIMER_EN) begin
          if (bus.TIMER_SEL != 2'b00) begin
            // The selection only matters here; later changes are ignored
            // because the duration now lives in r_rem.
            w_rem_nxt   = duration(bus.TIMER_SEL);
            w_presc_nxt = P_ZERO;
            w_state_nxt = S_RUN;
          end else begin
            w_sel_err_nxt = 1'b1;
          end
        end
      end

`ifdef WASH_TIMER_PAUSE_EN
      S_RUN, S_PAUSE: begin
`else
      S_RUN: begin
`endif
        if (!bus.TIMER_EN) begin
          // Abort outranks both expiry and pause.
          w_state_nxt = S_IDLE;
          w_rem_nxt   = C_ZERO;
          w_presc_nxt = P_ZERO;
        end
`ifdef WASH_TIMER_PAUSE_EN
        else if (!bus.DOOR_SENSOR) begin
          // Door open: freeze counters; also defers an expiry on this edge.
          w_state_nxt = S_PAUSE;
        end
`endif
        else begin
          // Counting edge.  A resume edge out of PAUSE counts as well, so
          // the run is stretched by exactly the number of door-open edges.
          w_state_nxt = S_RUN;
          if (r_presc == P_MAX) begin
            w_presc_nxt = P_ZERO;
            if (r_rem <= C_ONE) begin
              w_rem_nxt   = C_ZERO;
              w_state_nxt = S_EXPIRED;
            end else begin
              w_rem_nxt = r_rem - C_ONE;
            end
          end else begin
            w_presc_nxt = r_presc + P_ONE;
          end
        end
      end

      S_EXPIRED: begin
        // Holding the request keeps TIMER_DONE up; only a low cycle re-arms.
        if (!bus.TIMER_EN) begin
          w_state_nxt = S_IDLE;
          w_rem_nxt   = C_ZERO;
          w_presc_nxt = P_ZERO;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_rem_nxt   = C_ZERO;
        w_presc_nxt = P_ZERO;
      end
    endcase
  end

  assign bus.TIMER_DONE = (r_state == S_EXPIRED);
  assign bus.BUSY       = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign bus.REMAINING  = r_rem;
  assign bus.SEL_ERR    = r_sel_err;

endmodule

// File: tb/tb_wash_timer_ctrl.sv
// tb_wash_timer_ctrl
//   Directed bench for wash_timer_ctrl with PRESCALE=4, T_MED=3, T_HIGH=5,
//   T_SPIN=2.  Inputs change and outputs are sampled 1 ns after each rising
//   edge.
module tb_wash_timer_ctrl;

  localparam int CNT_W = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  wash_timer_if #(.CNT_W(CNT_W)) bus ();

  wash_timer_ctrl #(
    .PRESCALE (4),
    .T_MED    (3),
    .T_HIGH   (5),
    .T_SPIN   (2),
    .CNT_W    (CNT_W)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    bus.TIMER_EN    = 1'b0;
    bus.TIMER_SEL   = 2'b00;
    bus.DOOR_SENSOR = 1'b1;

    // Reset
    RST = 1'b0;
    tick(2);
    chk("rst_done", 32'(bus.TIMER_DONE), 0);
    chk("rst_busy", 32'(bus.BUSY), 0);
    chk("rst_rem",  32'(bus.REMAINING), 0);
    chk("rst_err",  32'(bus.SEL_ERR), 0);
    RST = 1'b1;
    tick(1);
    chk("idle_busy", 32'(bus.BUSY), 0);

    // Medium run: 3 ticks of 4 cycles, done 12 edges after the start edge
    bus.TIMER_EN  = 1'b1;
    bus.TIMER_SEL = 2'b01;
    tick(1);
    chk("med_busy0", 32'(bus.BUSY), 1);
    chk("med_rem0",  32'(bus.REMAINING), 3);
    bus.TIMER_SEL = 2'b10;   // must be ignored mid-run
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk($sformatf("med_rem%0d", k),  32'(bus.REMAINING), 32'(3 - k / 4));
      chk($sformatf("med_done%0d", k), 32'(bus.TIMER_DONE), (k == 12) ? 1 : 0);
      chk($sformatf("med_busy%0d", k), 32'(bus.BUSY), (k < 12) ? 1 : 0);
    end
    tick(2);
    chk("med_hold_done", 32'(bus.TIMER_DONE), 1);
    chk("med_hold_rem",  32'(bus.REMAINING), 0);
    bus.TIMER_EN = 1'b0;
    tick(1);
    chk("med_idle_done", 32'(bus.TIMER_DONE), 0);
    chk("med_idle_busy", 32'(bus.BUSY), 0);
    chk("med_idle_rem",  32'(bus.REMAINING), 0);

    // Invalid selection
    bus.TIMER_EN  = 1'b1;
    bus.TIMER_SEL = 2'b00;
    tick(1);
    chk("sel_err",      32'(bus.SEL_ERR), 1);
    chk("sel_err_busy", 32'(bus.BUSY), 0);
    chk("sel_err_rem",  32'(bus.REMAINING), 0);
    bus.TIMER_EN = 1'b0;
    tick(1);
    chk("sel_err_clr",  32'(bus.SEL_ERR), 0);
    chk("sel_err_idle", 32'(bus.BUSY), 0);

    // High run aborted after 7 cycles
    bus.TIMER_EN  = 1'b1;
    bus.TIMER_SEL = 2'b10;
    tick(1);
    chk("high_rem0", 32'(bus.REMAINING), 5);
    tick(7);
    chk("high_rem7", 32'(bus.REMAINING), 4);
    bus.TIMER_EN = 1'b0;
    tick(1);
    chk("abort_busy", 32'(bus.BUSY), 0);
    chk("abort_rem",  32'(bus.REMAINING), 0);
    chk("abort_done", 32'(bus.TIMER_DONE), 0);
    tick(10);
    chk("abort_done_late", 32'(bus.TIMER_DONE), 0);

    // Reset mid-run, then full restart
    bus.TIMER_EN  = 1'b1;
    bus.TIMER_SEL = 2'b01;
    tick(1);
    chk("rr_rem0", 32'(bus.REMAINING), 3);
    tick(4);
    chk("rr_rem4", 32'(bus.REMAINING), 2);
    RST = 1'b0;
    tick(1);
    chk("rr_done", 32'(bus.TIMER_DONE), 0);
    chk("rr_busy", 32'(bus.BUSY), 0);
    chk("rr_rem",  32'(bus.REMAINING), 0);
    chk("rr_err",  32'(bus.SEL_ERR), 0);
    RST = 1'b1;
    tick(1);
    chk("rs_busy0", 32'(bus.BUSY), 1);
    chk("rs_rem0",  32'(bus.REMAINING), 3);
    tick(11);
    chk("rs_done11", 32'(bus.TIMER_DONE), 0);
    chk("rs_rem11",  32'(bus.REMAINING), 1);
    tick(1);
    chk("rs_done12", 32'(bus.TIMER_DONE), 1);

    // Expired hold, one low cycle, spin restart
    tick(4);
    chk("exp_hold5", 32'(bus.TIMER_DONE), 1);
    chk("exp_busy",  32'(bus.BUSY), 0);
    bus.TIMER_EN = 1'b0;
    tick(1);
    chk("exp_idle_done", 32'(bus.TIMER_DONE), 0);
    chk("exp_idle_busy", 32'(bus.BUSY), 0);
    bus.TIMER_EN  = 1'b1;
    bus.TIMER_SEL = 2'b11;
    tick(1);
    chk("spin_busy0", 32'(bus.BUSY), 1);
    chk("spin_rem0",  32'(bus.REMAINING), 2);
    tick(7);
    chk("spin_done7", 32'(bus.TIMER_DONE), 0);
    chk("spin_rem7",  32'(bus.REMAINING), 1);
    tick(1);
    chk("spin_done8", 32'(bus.TIMER_DONE), 1);
    bus.TIMER_EN = 1'b0;
    tick(1);
    chk("spin_idle", 32'(bus.TIMER_DONE), 0);

    // Door opened for 6 edges mid spin run
    bus.TIMER_EN  = 1'b1;
    bus.TIMER_SEL = 2'b11;
    tick(1);
    chk("door_rem0", 32'(bus.REMAINING), 2);
    tick(2);
    bus.DOOR_SENSOR = 1'b0;
    tick(6);
`ifdef WASH_TIMER_PAUSE_EN
    chk("pause_busy", 32'(bus.BUSY), 1);
    chk("pause_rem",  32'(bus.REMAINING), 2);
    chk("pause_done", 32'(bus.TIMER_DONE), 0);
    bus.DOOR_SENSOR = 1'b1;
    tick(5);
    chk("pause_done13", 32'(bus.TIMER_DONE), 0);
    tick(1);
    chk("pause_done14", 32'(bus.TIMER_DONE), 1);
`else
    // Door input ignored: run finishes at 8 edges regardless
    chk("nopause_done8", 32'(bus.TIMER_DONE), 1);
    chk("nopause_rem",   32'(bus.REMAINING), 0);
    bus.DOOR_SENSOR = 1'b1;
`endif
    bus.TIMER_EN = 1'b0;
    tick(1);
    chk("final_idle", 32'(bus.BUSY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
